// File: rtl/regfile_bypass.sv
// Multi-ported register file: port-priority writes with collision flag, same-cycle
// write-to-read bypass, hardwired zero entry and a post-reset clearing sequencer.
module regfile_bypass #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      SIZE      = 64,
   parameter int unsigned      NUM_READ  = 8,
   parameter int unsigned      NUM_WRITE = 4,
   parameter bit               ZERO_REG  = 1'b1,
   parameter bit               BYPASS    = 1'b1,
   parameter logic [WIDTH-1:0] INIT_VAL  = '0,
   localparam int unsigned     AW        = $clog2(SIZE)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_READ-1:0]                 IN_re,
   input  logic [NUM_READ-1:0][AW-1:0]         IN_raddr,
   output logic [NUM_READ-1:0][WIDTH-1:0]      OUT_rdata,
   input  logic [NUM_WRITE-1:0]                IN_we,
   input  logic [NUM_WRITE-1:0][AW-1:0]        IN_waddr,
   input  logic [NUM_WRITE-1:0][WIDTH-1:0]     IN_wdata,
   output logic                                OUT_ready,
   output logic                                OUT_collide
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);

   state_t                             r_state, w_state_nxt;
   logic [AW-1:0]                      r_cnt;
   logic [WIDTH-1:0]                   r_mem [SIZE];
   logic [NUM_READ-1:0][WIDTH-1:0]     r_rdata;
   logic                               r_collide;
   logic [NUM_READ-1:0][WIDTH-1:0]     w_rdata_nxt;
   logic [NUM_WRITE-1:0]               w_wen;
   logic                               w_collide;
   logic                               w_run;

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < SIZE_W;
   endfunction

   assign w_run       = (r_state == S_RUN);
   assign OUT_ready   = w_run;
   assign OUT_rdata   = r_rdata;
   assign OUT_collide = r_collide;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_INIT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_INIT && r_cnt == AW'(SIZE-1)) w_state_nxt = S_RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                r_cnt <= '0;
      else if (r_state == S_INIT) r_cnt <= r_cnt + AW'(1);
   end

   always_comb begin
      w_wen = '0;
      for (int unsigned j = 0; j < NUM_WRITE; j++)
         w_wen[j] = IN_we[j] && w_run && in_range(IN_waddr[j]) &&
                    !(ZERO_REG && IN_waddr[j] == '0);
   end

   always_comb begin
      w_collide = 1'b0;
      for (int unsigned j = 0; j < NUM_WRITE; j++)
         for (int unsigned k = j + 1; k < NUM_WRITE; k++)
            if (w_wen[j] && w_wen[k] && IN_waddr[j] == IN_waddr[k]) w_collide = 1'b1;
   end

   // Ascending scan: the highest-index matching write port ends up forwarded.
   always_comb begin
      w_rdata_nxt = r_rdata;
      for (int unsigned i = 0; i < NUM_READ; i++) begin
         if (w_run && IN_re[i]) begin
            if (!in_range(IN_raddr[i]) || (ZERO_REG && IN_raddr[i] == '0)) begin
               w_rdata_nxt[i] = '0;
            end else begin
               w_rdata_nxt[i] = r_mem[IN_raddr[i]];
               if (BYPASS)
                  for (int unsigned j = 0; j < NUM_WRITE; j++)
                     if (w_wen[j] && IN_waddr[j] == IN_raddr[i]) w_rdata_nxt[i] = IN_wdata[j];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdata   <= '0;
         r_collide <= 1'b0;
      end else begin
         r_rdata   <= w_rdata_nxt;
         r_collide <= w_collide;
      end
   end

   // Later non-blocking writes override earlier ones, so the highest port wins.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == S_INIT) r_mem[r_cnt] <= INIT_VAL;
         for (int unsigned j = 0; j < NUM_WRITE; j++)
            if (w_wen[j]) r_mem[IN_waddr[j]] <= IN_wdata[j];
      end
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based model, directed vectors and corner sequences.
module tb_regfile_bypass;

   localparam int          NR    = 8;
   localparam int          NW    = 4;
   localparam int          SZ    = 64;
   localparam logic [31:0] INITV = 32'hDEADBEEF;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NR-1:0]        re;
   logic [NR-1:0][5:0]   raddr;
   logic [NW-1:0]        we;
   logic [NW-1:0][5:0]   waddr;
   logic [NW-1:0][31:0]  wdata;
   logic [NR-1:0][31:0]  rdata, rdata_nb;
   logic                 ready, ready_nb, collide, collide_nb;

   logic [31:0]          m_mem [SZ];
   int                   m_cnt;
   logic                 m_rdy;
   logic [NR-1:0][31:0]  e_rd, e_rd_nb;
   logic                 e_col;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [NW-1:0]       we;
      logic [NW-1:0][5:0]  waddr;
      logic [NW-1:0][31:0] wdata;
      logic [NR-1:0]       re;
      logic [NR-1:0][5:0]  raddr;
      int                  rport;
      logic [31:0]         exp_byp;
      logic [31:0]         exp_nb;
      logic                exp_col;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   regfile_bypass #(.WIDTH(32), .SIZE(SZ), .NUM_READ(NR), .NUM_WRITE(NW),
                    .ZERO_REG(1'b1), .BYPASS(1'b1), .INIT_VAL(INITV)) u_dut (
      .clk(clk), .rst_n(rst_n), .IN_re(re), .IN_raddr(raddr), .OUT_rdata(rdata),
      .IN_we(we), .IN_waddr(waddr), .IN_wdata(wdata), .OUT_ready(ready),
      .OUT_collide(collide));

   regfile_bypass #(.WIDTH(32), .SIZE(SZ), .NUM_READ(NR), .NUM_WRITE(NW),
                    .ZERO_REG(1'b1), .BYPASS(1'b0), .INIT_VAL(INITV)) u_nb (
      .clk(clk), .rst_n(rst_n), .IN_re(re), .IN_raddr(raddr), .OUT_rdata(rdata_nb),
      .IN_we(we), .IN_waddr(waddr), .IN_wdata(wdata), .OUT_ready(ready_nb),
      .OUT_collide(collide_nb));

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference behaviour for one clock edge, evaluated on the inputs about to be sampled.
   task automatic model_eval();
      bit          eff [NW];
      int          hits [SZ];
      bit          taken [SZ];
      logic [31:0] v;
      foreach (hits[a]) begin hits[a] = 0; taken[a] = 0; end
      if (!rst_n) begin
         m_rdy = 0; m_cnt = 0; e_rd = '0; e_rd_nb = '0; e_col = 0;
         return;
      end
      if (!m_rdy) begin
         m_mem[m_cnt] = INITV;
         m_cnt++;
         if (m_cnt == SZ) m_rdy = 1;
         e_col = 0;
         return;
      end
      e_col = 0;
      for (int j = 0; j < NW; j++) begin
         eff[j] = we[j] && (waddr[j] != 0);
         if (eff[j]) begin
            hits[waddr[j]]++;
            if (hits[waddr[j]] > 1) e_col = 1;
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (re[i]) begin
            if (raddr[i] == 0) begin
               e_rd[i] = 0; e_rd_nb[i] = 0;
            end else begin
               v = m_mem[raddr[i]];
               e_rd_nb[i] = v;
               for (int j = NW - 1; j >= 0; j--)
                  if (eff[j] && waddr[j] == raddr[i]) begin v = wdata[j]; break; end
               e_rd[i] = v;
            end
         end
      end
      for (int j = NW - 1; j >= 0; j--)
         if (eff[j] && !taken[waddr[j]]) begin
            m_mem[waddr[j]] = wdata[j];
            taken[waddr[j]] = 1;
         end
   endtask

   task automatic step();
      model_eval();
      @(posedge clk);
      #1;
      chk("ready", ready, m_rdy);
      chk("ready_nb", ready_nb, m_rdy);
      chk("collide", collide, e_col);
      chk("collide_nb", collide_nb, e_col);
      chk("rdata", rdata, e_rd);
      chk("rdata_nb", rdata_nb, e_rd_nb);
   endtask

   task automatic idle();
      re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
   endtask

   task automatic rand_inputs();
      re = NR'($urandom);
      we = NW'($urandom);
      for (int i = 0; i < NR; i++)
         raddr[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
      for (int j = 0; j < NW; j++) begin
         waddr[j] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
         wdata[j] = $urandom;
      end
   endtask

   task automatic wait_init(input string nm);
      int n = 0;
      do begin
         rand_inputs();
         step();
         n++;
      end while (!ready && n < 200);
      chk(nm, n, 64);
   endtask

   task automatic sweep(input string nm);
      logic [31:0] ex;
      idle();
      for (int b = 0; b < SZ / NR; b++) begin
         re = '1;
         for (int i = 0; i < NR; i++) raddr[i] = 6'(b * NR + i);
         step();
         for (int i = 0; i < NR; i++) begin
            ex = (b == 0 && i == 0) ? 32'h0 : INITV;
            chk(nm, rdata[i], ex);
         end
      end
      idle();
   endtask

   function automatic vec_t rd(input int port, input logic [5:0] a, input logic [31:0] eb,
                               input logic [31:0] en, input logic col);
      vec_t v;
      v.we = '0; v.waddr = '0; v.wdata = '0; v.re = '0; v.raddr = '0;
      v.re[port] = 1'b1; v.raddr[port] = a; v.rport = port;
      v.exp_byp = eb; v.exp_nb = en; v.exp_col = col;
      return v;
   endfunction

   logic [31:0] hv;

   initial begin
      tbl[0] = rd(0, 6'd5, 32'h12345678, INITV, 1'b0);
      tbl[0].we[2] = 1'b1; tbl[0].waddr[2] = 6'd5; tbl[0].wdata[2] = 32'h12345678;
      tbl[1] = rd(0, 6'd5, 32'h12345678, 32'h12345678, 1'b0);
      tbl[2] = rd(3, 6'd9, 32'hAAAA0001, INITV, 1'b0);
      tbl[2].we[1] = 1'b1; tbl[2].waddr[1] = 6'd9; tbl[2].wdata[1] = 32'hAAAA0001;
      tbl[3] = rd(2, 6'd7, 32'h3, INITV, 1'b1);
      tbl[3].we[0] = 1'b1; tbl[3].waddr[0] = 6'd7; tbl[3].wdata[0] = 32'h1;
      tbl[3].we[3] = 1'b1; tbl[3].waddr[3] = 6'd7; tbl[3].wdata[3] = 32'h3;
      tbl[4] = rd(2, 6'd7, 32'h3, 32'h3, 1'b0);
      tbl[5] = rd(1, 6'd0, 32'h0, 32'h0, 1'b0);
      tbl[5].we = '1;
      for (int j = 0; j < NW; j++) begin tbl[5].waddr[j] = 6'd0; tbl[5].wdata[j] = 32'hFFFFFFFF; end
      tbl[6] = rd(1, 6'd0, 32'h0, 32'h0, 1'b0);
      tbl[7] = rd(5, 6'd63, INITV, INITV, 1'b0);

      rst_n = 1'b0;
      m_rdy = 0; m_cnt = 0; e_rd = '0; e_rd_nb = '0; e_col = 0;
      idle();
      step();
      step();
      chk("rst_ready", ready, 1'b0);
      chk("rst_rdata", rdata, '0);
      chk("rst_collide", collide, 1'b0);

      // Init with writes in flight: they must be ignored
      rst_n = 1'b1;
      wait_init("init_len");
      sweep("init_sweep");

      for (int k = 0; k < 8; k++) begin
         we = tbl[k].we; waddr = tbl[k].waddr; wdata = tbl[k].wdata;
         re = tbl[k].re; raddr = tbl[k].raddr;
         step();
         chk("tbl_byp", rdata[tbl[k].rport], tbl[k].exp_byp);
         chk("tbl_nb", rdata_nb[tbl[k].rport], tbl[k].exp_nb);
         chk("tbl_col", collide, tbl[k].exp_col);
      end
      idle();

      for (int n = 0; n < 1500; n++) begin
         rand_inputs();
         step();
      end

      hv = e_rd[4];
      for (int n = 0; n < 6; n++) begin
         rand_inputs();
         re[4] = 1'b0;
         step();
         chk("hold4", rdata[4], hv);
      end

      rst_n = 1'b0;
      rand_inputs();
      step();
      chk("midrun_ready", ready, 1'b0);
      chk("midrun_rdata", rdata, '0);
      rst_n = 1'b1;
      wait_init("reinit_len");
      sweep("reinit_sweep");

      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin rand_inputs(); step(); end
      rst_n = 1'b0;
      rand_inputs();
      step();
      rst_n = 1'b1;
      wait_init("midinit_len");
      for (int n = 0; n < 200; n++) begin rand_inputs(); step(); end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Multi-ported, parametrised physical register file for the backend, the next generation of the existing register file. It adds:
- same-cycle write-to-read bypass
- a hardwired zero entry
- deterministic write-port priority with a collision flag
- a post-reset initialisation sequencer that clears every entry before the file accepts traffic

It sits between the issue/operand-read stage (read ports) and the writeback stage (write ports).

## Interface
- WIDTH, 32, data width per entry
- SIZE, 64, number of entries; any value ≥ 2; address width is $clog2(SIZE)
- NUM_READ, 8, read ports
- NUM_WRITE, 4, write ports
- ZERO_REG, 1, if 1 entry 0 always reads 0 and writes to it are dropped
- BYPASS, 1, if 1 a same-cycle write to a read address is forwarded to the read result
- INIT_VAL, 0, WIDTH-bit value written to every entry by the init sequencer

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- IN_re  in  NUM_READ  per-port read enable
- IN_raddr  in  NUM_READ×$clog2(SIZE)  read addresses
- OUT_rdata  out  NUM_READ×WIDTH  registered read data
- IN_we  in  NUM_WRITE  per-port write enable
- IN_waddr  in  NUM_WRITE×$clog2(SIZE)  write addresses
- IN_wdata  in  NUM_WRITE×WIDTH  write data
- OUT_ready  out  1  high once initialisation is complete
- OUT_collide  out  1  registered flag: two or more effective writes hit the same address in the previous cycle

## Operation

**State machine**
- Two states: INIT and RUN.
- rst_n low: state := INIT, init counter := 0, OUT_ready := 0, all OUT_rdata := 0, OUT_collide := 0.
- INIT: each cycle, mem[cnt] := INIT_VAL and cnt := cnt + 1. After writing entry SIZE-1, state := RUN.
- During INIT, IN_re and IN_we are ignored. OUT_rdata and OUT_collide hold 0.
- RUN: state is held until rst_n is asserted again.

**Effective write**
- Port j writes only if IN_we[j] is set, the state is RUN, and not (ZERO_REG and IN_waddr[j]==0).

**Write priority**
- If several effective writes target one address, the highest port index wins; the others are discarded.
- OUT_collide := 1 on the next edge, otherwise 0. Writes to the zero entry never count as a collision.

**Read (state RUN, IN_re[i]=1)**, OUT_rdata[i] on the next edge is chosen in this order:
1. 0, if ZERO_REG and IN_raddr[i]==0.
2. Bypass, if BYPASS and any effective write matches IN_raddr[i]: IN_wdata of the highest matching port.
3. Otherwise mem[IN_raddr[i]], the value before this cycle's writes.

If IN_re[i]=0, OUT_rdata[i] holds its previous value.

**Widths**
- Addresses ≥ SIZE (non-power-of-two SIZE) are out of range. Writes to them are dropped. Reads from them return 0.

## Timing
- Read latency: 1 cycle from IN_re/IN_raddr to OUT_rdata.
- Write latency: a write at edge N is visible through the array to reads presented in cycle N+1. It is visible in cycle N only via bypass; with BYPASS=0 a same-cycle read returns the old value.
- Init duration: rst_n deasserted before edge E. Entries 0..SIZE-1 are written on edges E..E+SIZE-1. OUT_ready rises after edge E+SIZE-1, so reads and writes are accepted from the following cycle onward.
- Reset mid-INIT or mid-RUN: the next edge with rst_n low restarts from cnt=0. Contents are re-initialised and are not preserved.
- OUT_collide is a single-cycle pulse per colliding cycle, aligned with OUT_rdata of that cycle.
- Reset values: OUT_rdata=0, OUT_ready=0, OUT_collide=0.

## Test plan
- **Init sequence.** Release rst_n with SIZE=64 and INIT_VAL=0xDEADBEEF; drive writes throughout init. Required: OUT_ready=0 for 64 cycles, then 1. Writes issued during INIT have no effect. Reading entries 0..63 afterwards returns 0xDEADBEEF, except entry 0, which returns 0 with ZERO_REG=1.
- **Basic write then read.** Port 2 writes 0x12345678 to addr 5 at edge N; port 0 reads addr 5 in cycle N+1. Required: OUT_rdata[0]=0x12345678 at edge N+2.
- **Bypass.** In the same cycle, port 1 writes 0xAAAA0001 to addr 9 and read port 3 reads addr 9. Required with BYPASS=1: 0xAAAA0001 on the next edge. Required with BYPASS=0: the prior value of entry 9.
- **Write collision.** Ports 0 and 3 write 0x1 and 0x3 to addr 7 in one cycle. Required: OUT_collide=1 for exactly one cycle, and a later read of addr 7 returns 0x3. A same-cycle bypass read of addr 7 also returns 0x3.
- **Zero register.** Write 0xFFFFFFFF to addr 0 from all ports while reading addr 0. Required: the read returns 0 now and later, and OUT_collide=0.
- **Hold and reset.** With IN_re[4]=0 for several cycles, OUT_rdata[4] stays constant. Assert rst_n low mid-RUN for one cycle. Required: outputs return to 0, OUT_ready drops, and the full init is repeated.
